// File: rtl/cfu_dispatch.sv
// cfu_dispatch: CFU front-end dispatcher.
// Decodes funct3 of each CPU CFU command and routes it to one of NUM_FU
// functional units (FU i serves funct3 == i). The selected unit's response
// is registered and returned to the CPU. Unmapped funct3 values receive
// ERR_CODE immediately instead of stalling.
//
// Optional feature, enabled by defining CFU_DISPATCH_PERF_EN:
//   per-FU saturating command counters plus one counter for unmapped
//   commands, readable with funct3 == PERF_ID (counter index in funct7[2:0],
//   funct7[6] clears all counters after the read). When the macro is not
//   defined there are no counters and PERF_ID is treated as unmapped.
//
// Handshake rules (all channels): a transfer happens on a rising clock edge
// where valid and ready are both high. A source holds valid and its payload
// stable until that edge; ready may depend combinationally on valid.
// Only one command is in flight, so responses can never be reordered.
module cfu_dispatch #(
  parameter int          NUM_FU     = 3,
  parameter logic [31:0] ERR_CODE   = 32'hDEAD_C0DE,
  parameter int          PERF_ID    = 7,
  parameter int          PERF_CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [9:0]            cmd_payload_function_id,
  input  logic [31:0]           cmd_payload_inputs_0,
  input  logic [31:0]           cmd_payload_inputs_1,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_payload_outputs_0,
  output logic [NUM_FU-1:0]     fu_cmd_valid,
  input  logic [NUM_FU-1:0]     fu_cmd_ready,
  output logic [9:0]            fu_function_id,
  output logic [31:0]           fu_inputs_0,
  output logic [31:0]           fu_inputs_1,
  input  logic [NUM_FU-1:0]     fu_rsp_valid,
  output logic [NUM_FU-1:0]     fu_rsp_ready,
  input  logic [32*NUM_FU-1:0]  fu_rsp_data,
  output logic                  busy,
  output logic                  err_unmapped,
  output logic [1:0]            dbg_state
);

  // Elaboration-time sanity check of the parameter set.
  if (NUM_FU < 1 || NUM_FU > 7 || PERF_ID < NUM_FU || PERF_ID > 7 ||
      PERF_CNT_W < 1 || PERF_CNT_W > 32) begin : g_param_err
    $error("cfu_dispatch: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_FU = 2'd1,
    ST_RSP     = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_sel;
  logic [31:0] r_rsp;
  logic        r_err;

  logic [2:0]  w_funct3;
  logic        w_mapped;
  logic        w_accept;
  logic        w_is_perf;
  logic [31:0] w_perf_rd;
  logic        w_sel_cmd_ready;
  logic        w_sel_rsp_valid;
  logic [31:0] w_sel_rsp_data;

  assign w_funct3 = cmd_payload_function_id[2:0];
  assign w_mapped = ({1'b0, w_funct3} < 4'(NUM_FU));
  assign w_accept = (r_state == ST_IDLE) && cmd_valid && cmd_ready;

  // Command payload is broadcast; only the one-hot valid selects the unit.
  assign fu_function_id        = cmd_payload_function_id;
  assign fu_inputs_0           = cmd_payload_inputs_0;
  assign fu_inputs_1           = cmd_payload_inputs_1;
  assign rsp_payload_outputs_0 = r_rsp;
  assign err_unmapped          = r_err;
  assign busy                  = (r_state != ST_IDLE);
  assign dbg_state             = r_state;

  // Per-unit muxes: ready of the decoded unit, response of the latched unit.
  always_comb begin
    w_sel_cmd_ready = 1'b0;
    w_sel_rsp_valid = 1'b0;
    w_sel_rsp_data  = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (w_funct3 == 3'(i)) begin
        w_sel_cmd_ready = fu_cmd_ready[i];
      end
      if (r_sel == 3'(i)) begin
        w_sel_rsp_valid = fu_rsp_valid[i];
        w_sel_rsp_data  = fu_rsp_data[32*i +: 32];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and handshake outputs.
  always_comb begin
    w_state_nxt  = r_state;
    cmd_ready    = 1'b0;
    rsp_valid    = 1'b0;
    fu_cmd_valid = '0;
    fu_rsp_ready = '0;
    case (r_state)
      ST_IDLE: begin
        // Unmapped and perf-read commands never stall the CPU.
        cmd_ready = w_mapped ? w_sel_cmd_ready : 1'b1;
        for (int i = 0; i < NUM_FU; i++) begin
          if (w_mapped && (w_funct3 == 3'(i))) begin
            fu_cmd_valid[i] = cmd_valid;
          end
        end
        if (cmd_valid && cmd_ready) begin
          w_state_nxt = w_mapped ? ST_WAIT_FU : ST_RSP;
        end
      end
      ST_WAIT_FU: begin
        // Only the selected unit is drained; others stay stalled.
        for (int i = 0; i < NUM_FU; i++) begin
          if (r_sel == 3'(i)) begin
            fu_rsp_ready[i] = 1'b1;
          end
        end
        if (w_sel_rsp_valid) begin
          w_state_nxt = ST_RSP;
        end
      end
      ST_RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Unit select, response register and unmapped-error pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sel <= '0;
      r_rsp <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (w_accept) begin
        if (w_mapped) begin
          r_sel <= w_funct3;
        end else if (w_is_perf) begin
          r_rsp <= w_perf_rd;
        end else begin
          r_rsp <= ERR_CODE;
          r_err <= 1'b1;
        end
      end
      if ((r_state == ST_WAIT_FU) && w_sel_rsp_valid) begin
        r_rsp <= w_sel_rsp_data;
      end
    end
  end

`ifdef CFU_DISPATCH_PERF_EN
  // Index NUM_FU is the unmapped-command counter.
  logic [PERF_CNT_W-1:0] r_cnt [NUM_FU+1];
  logic                  r_clr_pend;
  logic [3:0]            w_cnt_idx;
  logic [2:0]            w_rd_idx;

  assign w_is_perf = (w_funct3 == 3'(PERF_ID));
  assign w_cnt_idx = w_mapped ? {1'b0, w_funct3} : 4'(NUM_FU);
  assign w_rd_idx  = cmd_payload_function_id[5:3];

  // Counter read mux; indices beyond the unmapped counter read as zero.
  always_comb begin
    w_perf_rd = '0;
    for (int i = 0; i <= NUM_FU; i++) begin
      if (w_rd_idx == 3'(i)) begin
        w_perf_rd[PERF_CNT_W-1:0] = r_cnt[i];
      end
    end
  end

  // Saturating counters; a clear request applies one cycle after the read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clr_pend <= 1'b0;
      for (int i = 0; i <= NUM_FU; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_clr_pend <= w_accept && w_is_perf && cmd_payload_function_id[9];
      if (r_clr_pend) begin
        for (int i = 0; i <= NUM_FU; i++) begin
          r_cnt[i] <= '0;
        end
      end else if (w_accept && !w_is_perf) begin
        for (int i = 0; i <= NUM_FU; i++) begin
          if ((w_cnt_idx == 4'(i)) && (r_cnt[i] != {PERF_CNT_W{1'b1}})) begin
            r_cnt[i] <= r_cnt[i] + 1'b1;
          end
        end
      end
    end
  end
`else
  assign w_is_perf = 1'b0;
  assign w_perf_rd = '0;
`endif

endmodule
